data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem.sv | 34 +++
 tb/tb_data_mem.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// Word-addressed data memory: clocked writes, combinational gated reads,
// and an asynchronous clear of every word while reset is low.
module data_mem #(
    parameter int unsigned W = 8,
    parameter int unsigned A = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [A-1:0] DataAddress,
    input  logic         ReadMem,
    input  logic         WriteMem,
    input  logic [W-1:0] DataIn,
    output logic [W-1:0] DataOut
);

    localparam int unsigned DEPTH = 2 ** A;

    logic [W-1:0] mem_core [0:2**A-1];

    // Reset wipes the whole array; writes are ignored until reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_core[i] <= W'(0);
            end
        end else if (WriteMem) begin
            mem_core[DataAddress] <= DataIn;
        end
    end

    // No write bypass: a same-address write shows up only after its edge.
    assign DataOut = (reset && ReadMem) ? mem_core[DataAddress] : W'(0);

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: a per-cycle comparison against an array model,
// plus hand-computed checks of read gating, read-during-write and reset.
`timescale 1ns/1ps
module tb_data_mem;

    logic       clk;
    logic       reset;
    logic [7:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] din;
    logic [7:0] dout;

    int n_tests;
    int n_fail;
    bit armed;

    logic [7:0] model [0:255];

    data_mem #(.W(8), .A(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .DataAddress(addr),
        .ReadMem    (rd),
        .WriteMem   (wr),
        .DataIn     (din),
        .DataOut    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference memory: a word changes only on a clock edge with reset released.
    always @(posedge clk) begin
        if (reset === 1'b1 && wr === 1'b1) model[addr] = din;
    end

    always @(negedge reset) begin
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cycle_model", dout, (reset && rd) ? model[addr] : 8'h00);
        end
    end

    // Advance to 2 ns after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        armed   = 1'b0;
        reset   = 1'b1;
        addr    = 8'h00;
        rd      = 1'b0;
        wr      = 1'b0;
        din     = 8'h00;

        #2 reset = 1'b0;
        #1 armed = 1'b1;
        check("reset_dout", dout, 8'h00);
        next_cycle();
        next_cycle();
        reset = 1'b1;

        // Every word reads zero after reset.
        rd = 1'b1;
        for (int i = 0; i < 256; i++) begin
            next_cycle();
            addr = 8'(i);
            #1 check("sweep_zero", dout, 8'h00);
        end

        // Write A5 to 03; old contents visible before the edge.
        next_cycle();
        addr = 8'h03; din = 8'hA5; wr = 1'b1;
        #1 check("rdw_03_old", dout, 8'h00);
        next_cycle();
        wr = 1'b0; addr = 8'h02;
        #1 check("neighbour_02", dout, 8'h00);
        addr = 8'h03;
        #1 check("readback_03", dout, 8'hA5);

        // Read gating reacts within the cycle.
        next_cycle();
        rd = 1'b0;
        #1 check("gated_03", dout, 8'h00);
        rd = 1'b1;
        #1 check("ungated_03", dout, 8'hA5);

        // Same-address read-during-write at 10.
        next_cycle();
        addr = 8'h10; din = 8'h11; wr = 1'b1;
        next_cycle();
        din = 8'h22;
        #1 check("rdw_10_old", dout, 8'h11);
        next_cycle();
        wr = 1'b0;
        #1 check("rdw_10_new", dout, 8'h22);

        // WriteMem low leaves a word intact even with new data presented.
        next_cycle();
        addr = 8'h03; din = 8'hFF;
        next_cycle();
        #1 check("no_write_03", dout, 8'hA5);

        // Hierarchical deposits are visible immediately.
        next_cycle();
        dut.mem_core[1] = 8'h80; model[1] = 8'h80;
        dut.mem_core[0] = 8'h00; model[0] = 8'h00;
        addr = 8'h01;
        #1 check("deposit_01", dout, 8'h80);
        addr = 8'h00;
        #1 check("deposit_00", dout, 8'h00);

        // Top word.
        next_cycle();
        addr = 8'hFF; din = 8'h3C; wr = 1'b1;
        next_cycle();
        wr = 1'b0;
        #1 check("top_ff", dout, 8'h3C);

        // Reset between edges clears everything before the next edge.
        next_cycle();
        addr = 8'h03;
        #0.5 reset = 1'b0;
        #0.5 check("midreset_03", dout, 8'h00);
        addr = 8'hFF;
        #0.5 check("midreset_ff", dout, 8'h00);
        rd = 1'b0;
        #0.5 check("midreset_rd0", dout, 8'h00);
        rd = 1'b1;

        // Writes attempted during reset are dropped.
        next_cycle();
        addr = 8'h55; din = 8'h77; wr = 1'b1;
        next_cycle();
        wr = 1'b0;
        #1 check("reset_write_dropped_rd", dout, 8'h00);
        reset = 1'b1;
        #1 check("reset_write_dropped", dout, 8'h00);
        addr = 8'h10;
        #1 check("reset_cleared_10", dout, 8'h00);

        // Memory writable again after release.
        next_cycle();
        addr = 8'h55; din = 8'h9C; wr = 1'b1;
        next_cycle();
        wr = 1'b0;
        #1 check("post_reset_55", dout, 8'h9C);

        next_cycle();
        next_cycle();
        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
